// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the LEGv8 multicycle control unit: FSM states, opcode
// classes, opcode match patterns and ALUOp codes.
package legv8_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_LDUR = 3'd1,
        CLS_STUR = 3'd2,
        CLS_CBZ  = 3'd3,
        CLS_ILL  = 3'd4
    } op_class_t;

    // R-type is 1xx0101x000: mask keeps the fixed bits, value holds them.
    localparam logic [10:0] OP_R_MASK   = 11'b10011110111;
    localparam logic [10:0] OP_R_VAL    = 11'b10001010000;
    localparam logic [10:0] OP_LDUR     = 11'b11111000010;
    localparam logic [10:0] OP_STUR     = 11'b11111000000;
    localparam logic [10:0] OP_CBZ_MASK = 11'b11111111000;
    localparam logic [10:0] OP_CBZ_VAL  = 11'b10110100000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASS  = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction/status inputs and datapath control outputs of the multicycle
// control unit; the master drives inputs, the controller is the slave.
interface multicycle_ctrl_if;
    logic [10:0] insOp;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite;
    logic        IRWrite;
    logic        ALUSrc;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        MemtoReg;
    logic        Reg2Loc;
    logic        PCSrc;
    logic [1:0]  ALUOp;
    logic [2:0]  state;
    logic        trap;

    modport master (
        output insOp, zero, mem_ready,
        input  PCWrite, IRWrite, ALUSrc, MemRead, MemWrite, RegWrite,
               MemtoReg, Reg2Loc, PCSrc, ALUOp, state, trap
    );

    modport slave (
        input  insOp, zero, mem_ready,
        output PCWrite, IRWrite, ALUSrc, MemRead, MemWrite, RegWrite,
               MemtoReg, Reg2Loc, PCSrc, ALUOp, state, trap
    );
endinterface

// File: rtl/legv8_op_decode.sv
// Combinational opcode classifier: maps the 11-bit insOp field to one of the
// supported instruction classes, anything unmatched is ILLEGAL.
module legv8_op_decode
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0] insOp_i,
    output op_class_t   class_o
);

    always_comb begin
        class_o = CLS_ILL;
        if ((insOp_i & OP_R_MASK) == OP_R_VAL) begin
            class_o = CLS_R;
        end else if (insOp_i == OP_LDUR) begin
            class_o = CLS_LDUR;
        end else if (insOp_i == OP_STUR) begin
            class_o = CLS_STUR;
        end else if ((insOp_i & OP_CBZ_MASK) == OP_CBZ_VAL) begin
            class_o = CLS_CBZ;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// LEGv8 multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB with a bounded
// data-memory wait and a sticky TRAP state for illegal opcodes and timeouts.
module multicycle_ctrl
    import legv8_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.slave  bus
);

    localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t    state_q;
    op_class_t class_q;
    op_class_t dec_cls;
    op_class_t cls;
    logic [7:0] cnt_q;
    logic       trap_q;

    legv8_op_decode u_dec (
        .insOp_i (bus.insOp),
        .class_o (dec_cls)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            class_q <= CLS_R;
            cnt_q   <= '0;
            trap_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: state_q <= ST_DECODE;
                ST_DECODE: begin
                    class_q <= dec_cls;
                    if (dec_cls == CLS_ILL) begin
                        state_q <= ST_TRAP;
                        trap_q  <= 1'b1;
                    end else begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    cnt_q <= '0;
                    case (class_q)
                        CLS_R:              state_q <= ST_WB;
                        CLS_LDUR, CLS_STUR: state_q <= ST_MEM;
                        default:            state_q <= ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    // A ready on the last permitted cycle still completes the access.
                    if (bus.mem_ready) begin
                        state_q <= (class_q == CLS_LDUR) ? ST_WB : ST_FETCH;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_TRAP;
                        trap_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_WB:   state_q <= ST_FETCH;
                ST_TRAP: state_q <= ST_TRAP;
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    // The class is only registered at the end of DECODE, so DECODE itself looks at the live decode.
    assign cls = (state_q == ST_DECODE) ? dec_cls : class_q;

    always_comb begin
        bus.PCWrite  = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.ALUSrc   = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.RegWrite = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.Reg2Loc  = 1'b0;
        bus.PCSrc    = 1'b0;
        bus.ALUOp    = ALUOP_ADD;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    bus.PCWrite = 1'b1;
                    bus.IRWrite = 1'b1;
                end
                ST_DECODE: bus.Reg2Loc = (cls == CLS_STUR) || (cls == CLS_CBZ);
                ST_EXEC: begin
                    bus.Reg2Loc = (cls == CLS_STUR) || (cls == CLS_CBZ);
                    bus.ALUSrc  = (cls == CLS_LDUR) || (cls == CLS_STUR);
                    case (cls)
                        CLS_R:   bus.ALUOp = ALUOP_RTYPE;
                        CLS_CBZ: bus.ALUOp = ALUOP_PASS;
                        default: bus.ALUOp = ALUOP_ADD;
                    endcase
                    if (cls == CLS_CBZ) begin
                        bus.PCWrite = bus.zero;
                        bus.PCSrc   = bus.zero;
                    end
                end
                ST_MEM: begin
                    bus.MemRead  = (cls == CLS_LDUR);
                    bus.MemWrite = (cls == CLS_STUR);
                end
                ST_WB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = (cls == CLS_LDUR);
                end
                default: ;
            endcase
        end
    end

    assign bus.state = state_q;
    assign bus.trap  = trap_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected traces are
// built from the instruction-class rules and compared cycle by cycle.
module tb_multicycle_ctrl;

    localparam int TO = 15;
    localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_ILL = 4;

    int compared   = 0;
    int mismatched = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          e_st [64];
    logic [11:0] e_o  [64];
    logic        e_rdy[64];
    logic        e_z  [64];
    int          n_exp;
    logic [2:0]  obs_st[64];
    logic [11:0] obs_o [64];
    logic [4:0]  rst_en;

    function automatic int ref_class(input logic [10:0] op);
        casez (op)
            11'b1??0101?000: return C_R;
            11'b11111000010: return C_LD;
            11'b11111000000: return C_ST;
            11'b10110100???: return C_CBZ;
            default:         return C_ILL;
        endcase
    endfunction

    function automatic logic [11:0] pk(input bit pcw, input bit irw, input bit asrc,
                                       input bit mrd, input bit mwr, input bit rgw,
                                       input bit m2r, input bit r2l, input bit pcs,
                                       input bit [1:0] aop, input bit trp);
        return {pcw, irw, asrc, mrd, mwr, rgw, m2r, r2l, pcs, aop, trp};
    endfunction

    function automatic logic [11:0] obs();
        return {bus.PCWrite, bus.IRWrite, bus.ALUSrc, bus.MemRead, bus.MemWrite,
                bus.RegWrite, bus.MemtoReg, bus.Reg2Loc, bus.PCSrc, bus.ALUOp, bus.trap};
    endfunction

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    task automatic add(input int st, input logic [11:0] o, input logic rdy, input logic z);
        e_st[n_exp] = st; e_o[n_exp] = o; e_rdy[n_exp] = rdy; e_z[n_exp] = z;
        n_exp++;
    endtask

    // Expected trace of one instruction from FETCH; waits = mem_ready-low cycles in MEM.
    task automatic build(input logic [10:0] op, input logic z, input int waits, output bit trapped);
        int c;
        bit ld, st, cb, done;
        c = ref_class(op);
        ld = (c == C_LD); st = (c == C_ST); cb = (c == C_CBZ);
        n_exp = 0; trapped = 0; done = 0;
        add(0, pk(1,1,0,0,0,0,0,0,0,2'b00,0), rb(), rb());
        add(1, pk(0,0,0,0,0,0,0,st|cb,0,2'b00,0), rb(), rb());
        if (c == C_ILL) begin
            repeat (3) add(7, pk(0,0,0,0,0,0,0,0,0,2'b00,1), rb(), rb());
            trapped = 1;
            return;
        end
        add(2, pk(cb&z,0,ld|st,0,0,0,0,st|cb,cb&z,(c == C_R) ? 2'b10 : (cb ? 2'b01 : 2'b00),0),
            rb(), cb ? z : rb());
        if (ld | st) begin
            for (int i = 0; i < TO && !done; i++) begin
                done = (i == waits);
                add(3, pk(0,0,0,ld,st,0,0,0,0,2'b00,0), done, rb());
            end
            if (!done) begin
                repeat (3) add(7, pk(0,0,0,0,0,0,0,0,0,2'b00,1), rb(), rb());
                trapped = 1;
                return;
            end
        end
        if (c == C_R || ld) add(4, pk(0,0,0,0,0,1,ld,0,0,2'b00,0), rb(), rb());
    endtask

    // Drives the built trace (up to limit cycles) and records what the DUT shows.
    task automatic run_seq(input logic [10:0] op, input int limit);
        for (int i = 0; i < limit && i < n_exp; i++) begin
            bus.insOp = op; bus.zero = e_z[i]; bus.mem_ready = e_rdy[i];
            @(negedge clk);
            obs_st[i] = bus.state;
            obs_o[i]  = obs();
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.mem_ready = 1'b1; bus.zero = 1'b1;
        @(negedge clk);
        rst_en = {bus.PCWrite, bus.IRWrite, bus.MemRead, bus.MemWrite, bus.RegWrite};
        @(posedge clk); #1;
        rst = 1'b0; bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit tr;
        do_reset();
        compared++;
        if (rst_en !== 5'b0) begin mismatched++; $display("FAIL reset_enables: got %b expected 00000", rst_en); end
        build(11'b10001011000, 1'b0, 0, tr);
        run_seq(11'b10001011000, 1);
        compared++;
        if (obs_st[0] !== 3'd0) begin mismatched++; $display("FAIL reset_state: got %0d expected 0", obs_st[0]); end
        compared++;
        if (obs_o[0] !== e_o[0]) begin mismatched++; $display("FAIL reset_fetch_outs: got %b expected %b", obs_o[0], e_o[0]); end
        // finish the instruction so the next test starts in FETCH
        for (int i = 1; i < n_exp; i++) begin
            bus.zero = e_z[i]; bus.mem_ready = e_rdy[i];
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        bit tr;
        build(11'b10001011000, 1'b1, 0, tr);
        run_seq(11'b10001011000, n_exp);
        for (int i = 0; i < n_exp; i++) begin
            compared++;
            if (obs_st[i] !== 3'(e_st[i])) begin mismatched++; $display("FAIL rtype state[%0d]: got %0d expected %0d", i, obs_st[i], e_st[i]); end
            compared++;
            if (obs_o[i] !== e_o[i]) begin mismatched++; $display("FAIL rtype outs[%0d]: got %b expected %b", i, obs_o[i], e_o[i]); end
        end
    endtask

    task automatic test_ldur_wait();
        bit tr;
        int mem_cycles;
        build(11'b11111000010, 1'b0, 3, tr);
        run_seq(11'b11111000010, n_exp);
        mem_cycles = 0;
        for (int i = 0; i < n_exp; i++) begin
            if (obs_st[i] === 3'd3) mem_cycles++;
            compared++;
            if (obs_st[i] !== 3'(e_st[i])) begin mismatched++; $display("FAIL ldur state[%0d]: got %0d expected %0d", i, obs_st[i], e_st[i]); end
            compared++;
            if (obs_o[i] !== e_o[i]) begin mismatched++; $display("FAIL ldur outs[%0d]: got %b expected %b", i, obs_o[i], e_o[i]); end
        end
        compared++;
        if (mem_cycles != 4) begin mismatched++; $display("FAIL ldur_mem_len: got %0d expected 4", mem_cycles); end
    endtask

    task automatic test_cbz();
        bit tr;
        for (int k = 0; k < 2; k++) begin
            build(11'b10110100101, (k == 0), 0, tr);
            run_seq(11'b10110100101, n_exp);
            for (int i = 0; i < n_exp; i++) begin
                compared++;
                if (obs_st[i] !== 3'(e_st[i])) begin mismatched++; $display("FAIL cbz%0d state[%0d]: got %0d expected %0d", k, i, obs_st[i], e_st[i]); end
                compared++;
                if (obs_o[i] !== e_o[i]) begin mismatched++; $display("FAIL cbz%0d outs[%0d]: got %b expected %b", k, i, obs_o[i], e_o[i]); end
            end
        end
    endtask

    task automatic test_stur_timeout();
        bit tr;
        int mem_cycles;
        build(11'b11111000000, 1'b0, 1000, tr);
        run_seq(11'b11111000000, n_exp);
        mem_cycles = 0;
        for (int i = 0; i < n_exp; i++) begin
            if (obs_st[i] === 3'd3) mem_cycles++;
            compared++;
            if (obs_st[i] !== 3'(e_st[i])) begin mismatched++; $display("FAIL stur_to state[%0d]: got %0d expected %0d", i, obs_st[i], e_st[i]); end
            compared++;
            if (obs_o[i] !== e_o[i]) begin mismatched++; $display("FAIL stur_to outs[%0d]: got %b expected %b", i, obs_o[i], e_o[i]); end
        end
        compared++;
        if (mem_cycles != TO) begin mismatched++; $display("FAIL stur_to_mem_len: got %0d expected %0d", mem_cycles, TO); end
        do_reset();
        compared++;
        if (rst_en !== 5'b0) begin mismatched++; $display("FAIL stur_to_rst_enables: got %b expected 00000", rst_en); end
    endtask

    task automatic test_ready_wins();
        bit tr;
        logic [10:0] ops [2];
        ops[0] = 11'b11111000010; ops[1] = 11'b11111000000;
        for (int k = 0; k < 2; k++) begin
            build(ops[k], 1'b0, TO - 1, tr);
            run_seq(ops[k], n_exp);
            for (int i = 0; i < n_exp; i++) begin
                compared++;
                if (obs_st[i] !== 3'(e_st[i])) begin mismatched++; $display("FAIL ready_wins%0d state[%0d]: got %0d expected %0d", k, i, obs_st[i], e_st[i]); end
                compared++;
                if (obs_o[i] !== e_o[i]) begin mismatched++; $display("FAIL ready_wins%0d outs[%0d]: got %b expected %b", k, i, obs_o[i], e_o[i]); end
            end
        end
    endtask

    task automatic test_illegal();
        bit tr;
        build(11'b00000000000, 1'b0, 0, tr);
        run_seq(11'b00000000000, n_exp);
        for (int i = 0; i < n_exp; i++) begin
            compared++;
            if (obs_st[i] !== 3'(e_st[i])) begin mismatched++; $display("FAIL illegal state[%0d]: got %0d expected %0d", i, obs_st[i], e_st[i]); end
            compared++;
            if (obs_o[i] !== e_o[i]) begin mismatched++; $display("FAIL illegal outs[%0d]: got %b expected %b", i, obs_o[i], e_o[i]); end
        end
        do_reset();
        build(11'b10001011000, 1'b0, 0, tr);
        run_seq(11'b10001011000, n_exp);
        compared++;
        if (obs_st[0] !== 3'd0 || obs_o[0][0] !== 1'b0) begin
            mismatched++; $display("FAIL illegal_recover: got state %0d trap %b expected state 0 trap 0", obs_st[0], obs_o[0][0]);
        end
    endtask

    task automatic test_reset_mid_mem();
        bit tr;
        build(11'b11111000010, 1'b0, 10, tr);
        run_seq(11'b11111000010, 5);
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (obs_o[i] !== e_o[i]) begin mismatched++; $display("FAIL midmem outs[%0d]: got %b expected %b", i, obs_o[i], e_o[i]); end
        end
        compared++;
        if (obs_st[4] !== 3'd3) begin mismatched++; $display("FAIL midmem_in_mem: got %0d expected 3", obs_st[4]); end
        do_reset();
        compared++;
        if (rst_en !== 5'b0) begin mismatched++; $display("FAIL midmem_rst_enables: got %b expected 00000", rst_en); end
        build(11'b10110100000, 1'b0, 0, tr);
        run_seq(11'b10110100000, n_exp);
        for (int i = 0; i < n_exp; i++) begin
            compared++;
            if (obs_st[i] !== 3'(e_st[i])) begin mismatched++; $display("FAIL midmem_after state[%0d]: got %0d expected %0d", i, obs_st[i], e_st[i]); end
            compared++;
            if (obs_o[i] !== e_o[i]) begin mismatched++; $display("FAIL midmem_after outs[%0d]: got %b expected %b", i, obs_o[i], e_o[i]); end
        end
    endtask

    task automatic test_back_to_back_random();
        bit tr;
        logic [10:0] op;
        int c, waits, sel;
        for (int n = 0; n < 40; n++) begin
            c = $urandom_range(0, 4);
            case (c)
                C_R:   op = 11'b10001010000 | (11'($urandom) & 11'b01100001000);
                C_LD:  op = 11'b11111000010;
                C_ST:  op = 11'b11111000000;
                C_CBZ: op = 11'b10110100000 | (11'($urandom) & 11'b00000000111);
                default: begin
                    op = 11'($urandom);
                    while (ref_class(op) != C_ILL) op = 11'($urandom);
                end
            endcase
            sel = $urandom_range(0, 9);
            waits = (sel == 0) ? TO + 3 : (sel == 1) ? TO - 1 : $urandom_range(0, 4);
            build(op, rb(), waits, tr);
            run_seq(op, n_exp);
            for (int i = 0; i < n_exp; i++) begin
                compared++;
                if (obs_st[i] !== 3'(e_st[i])) begin mismatched++; $display("FAIL rand%0d op=%b state[%0d]: got %0d expected %0d", n, op, i, obs_st[i], e_st[i]); end
                compared++;
                if (obs_o[i] !== e_o[i]) begin mismatched++; $display("FAIL rand%0d op=%b outs[%0d]: got %b expected %b", n, op, i, obs_o[i], e_o[i]); end
            end
            if (tr) do_reset();
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            compared++;
            if ((bus.MemRead && bus.MemWrite) || (bus.RegWrite && bus.MemWrite)) begin
                mismatched++;
                $display("FAIL exclusive_enables: got MemRead=%b MemWrite=%b RegWrite=%b expected no overlap",
                         bus.MemRead, bus.MemWrite, bus.RegWrite);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal;
    end

    initial begin
        bus.insOp = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_rtype();
        test_ldur_wait();
        test_cbz();
        test_stur_timeout();
        test_ready_wins();
        test_illegal();
        test_reset_mid_mem();
        test_back_to_back_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
